// File: rtl/guvm_mem_pkg.sv
// Shared types and constants for the OBI-style memory responder.
// The pending-entry struct is sized from the package default widths below.
package guvm_mem_pkg;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_CNT_W  = 8;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit at bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic                  we;
        logic [PKG_CNT_W-1:0]  cnt;
    } pend_entry_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/guvm_mem_pending_fifo.sv
// Pending-request FIFO: DEPTH entries, every slot's latency counter ages in
// parallel, pointers wrap explicitly at DEPTH-1 so any DEPTH works.
module guvm_mem_pending_fifo
    import guvm_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OCC_W = $clog2(DEPTH+1),
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  pend_entry_t      push_entry,
    input  logic             pop,
    output logic             head_valid,
    output pend_entry_t      head,
    output logic             full,
    output logic [OCC_W-1:0] count
);

    pend_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            // Idle slots age too; they are overwritten with a fresh count on push.
            for (int i = 0; i < DEPTH; i++)
                if (mem[i].cnt != '0) mem[i].cnt <= mem[i].cnt - 1'b1;
            if (push) begin
                mem[wptr] <= push_entry;
                wptr      <= ptr_inc(wptr);
            end
            if (pop) rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head       = mem[rptr];
    assign full       = (count == OCC_W'(DEPTH));

endmodule

// File: rtl/guvm_mem_responder.sv
// OBI-style memory responder: bounded outstanding requests, fixed minimum
// latency, in-order responses. Optional random grant stall: GUVM_MEM_RAND_STALL_EN.
module guvm_mem_responder
    import guvm_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    output logic                       gnt_o,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic                       we_i,
    input  logic [DATA_W/8-1:0]        be_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic                       rvalid_o,
    output logic [DATA_W-1:0]          rdata_o,
    input  logic                       stim_valid_i,
    input  logic [DATA_W-1:0]          stim_data_i,
    output logic                       stim_ready_o,
    output logic [ADDR_W-1:0]          rsp_addr_o,
    output logic                       wr_valid_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic [DATA_W-1:0]          wr_data_o,
    output logic [DATA_W/8-1:0]        wr_be_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_o
);

    logic        stall, full, head_valid, accept;
    pend_entry_t head, push_entry;

`ifdef GUVM_MEM_RAND_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr <= LFSR_SEED;
        else       lfsr <= lfsr_next(lfsr);
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Grant depends only on registered occupancy, never on this cycle's pop.
    assign gnt_o  = req_i && !full && !stall && !rst_i;
    assign accept = gnt_o;

    always_comb begin
        push_entry      = '0;
        push_entry.addr = PKG_ADDR_W'(addr_i);
        push_entry.we   = we_i;
        push_entry.cnt  = PKG_CNT_W'(LATENCY-1);
    end

    guvm_mem_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (rvalid_o),
        .head_valid (head_valid),
        .head       (head),
        .full       (full),
        .count      (pending_o)
    );

    assign rvalid_o     = head_valid && (head.cnt == '0) && (head.we || stim_valid_i);
    assign stim_ready_o = rvalid_o && !head.we;
    assign rdata_o      = (head_valid && !head.we) ? stim_data_i : '0;
    assign rsp_addr_o   = head.addr[ADDR_W-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            wr_be_o    <= '0;
        end else begin
            wr_valid_o <= accept && we_i;
            if (accept && we_i) begin
                wr_addr_o <= addr_i;
                wr_data_o <= wdata_i;
                wr_be_o   <= be_i;
            end
        end
    end

endmodule

// File: tb/tb_guvm_mem_responder.sv
// Scoreboard bench for guvm_mem_responder: a queue of accepted requests with
// their earliest response cycle predicts grant, response and write capture.
module tb_guvm_mem_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW/8;
    localparam int DEPTH = 3;
    localparam int LAT   = 2;
    localparam int OW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0, we = 1'b0, stim_valid = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0, stim_data = '0;
    logic [BW-1:0] be = '0;
    logic          gnt, rvalid, stim_ready, wr_valid;
    logic [DW-1:0] rdata, wr_data;
    logic [AW-1:0] rsp_addr, wr_addr;
    logic [BW-1:0] wr_be;
    logic [OW-1:0] pending;

    always #5 clk = ~clk;

    guvm_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
        .stim_valid_i(stim_valid), .stim_data_i(stim_data), .stim_ready_o(stim_ready),
        .rsp_addr_o(rsp_addr), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .wr_be_o(wr_be), .pending_o(pending)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        int            ready_cyc;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0, checks = 0, cyc = 0;
    logic          exp_wv = 1'b0;
    logic [AW-1:0] exp_wa = '0;
    logic [DW-1:0] exp_wd = '0;
    logic [BW-1:0] exp_wb = '0;
    logic [15:0]   m_lfsr = 16'hACE1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare on the falling edge, then advance the model to the next edge.
    always @(negedge clk) begin : mon
        logic eg, er, st;
        exp_t e;
        if (rst) begin
            sb.delete();
            m_lfsr = 16'hACE1;
            exp_wv = 1'b0; exp_wa = '0; exp_wd = '0; exp_wb = '0;
            chk("rst_gnt", gnt, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_stim_ready", stim_ready, 0);
            chk("rst_wr_valid", wr_valid, 0);
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0);
            chk("rst_wr_be", wr_be, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_rsp_addr", rsp_addr, 0);
            chk("rst_pending", pending, 0);
        end else begin
`ifdef GUVM_MEM_RAND_STALL_EN
            st = (m_lfsr % 16'd4) == 16'd0;
`else
            st = 1'b0;
`endif
            eg = req && (sb.size() < DEPTH) && !st;
            er = (sb.size() > 0) ? ((cyc >= sb[0].ready_cyc) && (sb[0].we || stim_valid)) : 1'b0;
            chk("gnt", gnt, eg);
            chk("pending", pending, sb.size());
            chk("rvalid", rvalid, er);
            chk("stim_ready", stim_ready, er ? !sb[0].we : 1'b0);
            if (er) begin
                chk("rdata", rdata, sb[0].we ? '0 : stim_data);
                chk("rsp_addr", rsp_addr, sb[0].addr);
            end
            chk("wr_valid", wr_valid, exp_wv);
            chk("wr_addr", wr_addr, exp_wa);
            chk("wr_data", wr_data, exp_wd);
            chk("wr_be", wr_be, exp_wb);

            if (er) void'(sb.pop_front());
            if (eg) begin
                e.addr = addr; e.we = we; e.ready_cyc = cyc + LAT;
                sb.push_back(e);
            end
            exp_wv = eg && we;
            if (exp_wv) begin exp_wa = addr; exp_wd = wdata; exp_wb = be; end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Hold a request until it is granted (bounded).
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        logic g;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        for (int k = 0; k < 32; k++) begin
            #1; g = gnt;
            step();
            if (g) break;
        end
        req = 1'b0; we = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;

        // Single read, data always available
        stim_valid = 1'b1; stim_data = 32'hDEADBEEF;
        issue(1'b0, 32'h100, '0, '1);
        repeat (LAT + 2) step();

        // Fill with read data withheld, then drain in order
        stim_valid = 1'b0; req = 1'b1; we = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            addr = 32'h200 + 32'(i*4);
            stim_data = $urandom;
            step();
        end
        stim_valid = 1'b1;
        for (int i = 0; i < DEPTH + LAT + 3; i++) begin
            stim_data = $urandom;
            step();
        end
        req = 1'b0;
        repeat (LAT + 2) step();

        // Write capture
        issue(1'b1, 32'h20, 32'h55AA_1234, 4'b0011);
        repeat (LAT + 2) step();

        // Reset with requests outstanding
        stim_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 32'h300 + 32'(i*4), '0, '1);
        rst = 1'b1; step(); step();
        rst = 1'b0; stim_valid = 1'b1;
        repeat (10) step();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            req        = ($urandom_range(0, 99) < 60);
            we         = $urandom_range(0, 1) == 1;
            addr       = {$urandom_range(0, 32'hFFFF), 2'b00};
            wdata      = $urandom;
            be         = BW'($urandom);
            stim_valid = ($urandom_range(0, 99) < 70);
            stim_data  = $urandom;
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        // Continuous requests, data always available
        req = 1'b1; we = 1'b0; stim_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            addr = 32'h1000 + 32'(i*4);
            stim_data = $urandom;
            step();
        end
        req = 1'b0;
        repeat (DEPTH + LAT + 4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
